// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, 32-cycle RUN.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply (divides stay 32-cycle).
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_skip;
  logic [31:0] w_skip_res;

  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_run_res;

  // ---------------- operand decode ----------------
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_a_signed = ~funct3[0] | (funct3 == 3'b001);
  assign w_b_signed = (funct3[2] & ~funct3[0]) | (funct3[2:1] == 2'b00);
  assign w_a_neg    = w_a_signed & rs1_val[31];
  assign w_b_neg    = w_b_signed & rs2_val[31];
  assign w_a_mag    = w_a_neg ? (~rs1_val + 32'd1) : rs1_val;
  assign w_b_mag    = w_b_neg ? (~rs2_val + 32'd1) : rs2_val;

  assign w_div_zero = funct3[2] && (rs2_val == 32'd0);
  assign w_div_ovf  = funct3[2] && !funct3[0] &&
                      (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_fa;
  logic [63:0] w_fb;
  logic [63:0] w_fprod;

  // Low 64 bits of the extended-operand product are exact for every signedness mix.
  assign w_fa    = {{32{w_a_neg}}, rs1_val};
  assign w_fb    = {{32{w_b_neg}}, rs2_val};
  assign w_fprod = w_fa * w_fb;
  assign w_skip  = w_div_zero | w_div_ovf | ~funct3[2];
`else
  assign w_skip  = w_div_zero | w_div_ovf;
`endif

  always_comb begin
    w_skip_res = 32'd0;
    if (w_div_zero) begin
      w_skip_res = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
    end else if (w_div_ovf) begin
      w_skip_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!funct3[2]) begin
      w_skip_res = (funct3 == 3'b000) ? w_fprod[31:0] : w_fprod[63:32];
    end
`endif
  end

  // ---------------- iteration step ----------------
  // Multiply: {r_hi,r_lo} is the shifting product, r_lo starts as the multiplier.
  // Divide: r_hi is the partial remainder, r_lo shifts the dividend out and the quotient in.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_div_sh  = {r_hi, r_lo[31]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
  assign w_div_sub = w_div_sh[31:0] - r_b;

  always_comb begin
    w_hi_nx = 32'd0;
    w_lo_nx = 32'd0;
    if (r_op[2]) begin
      w_hi_nx = w_div_ge ? w_div_sub : w_div_sh[31:0];
      w_lo_nx = {r_lo[30:0], w_div_ge};
    end else begin
      w_hi_nx = w_mul_sum[32:1];
      w_lo_nx = {w_mul_sum[0], r_lo[31:1]};
    end
  end

  assign w_prod = r_neg_q ? (~{w_hi_nx, w_lo_nx} + 64'd1) : {w_hi_nx, w_lo_nx};
  assign w_quo  = r_neg_q ? (~w_lo_nx + 32'd1) : w_lo_nx;
  assign w_rem  = r_neg_r ? (~w_hi_nx + 32'd1) : w_hi_nx;

  always_comb begin
    w_run_res = 32'd0;
    if (r_op[2]) begin
      w_run_res = r_op[1] ? w_rem : w_quo;
    end else begin
      w_run_res = (r_op == 3'b000) ? w_prod[31:0] : w_prod[63:32];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    stall      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = start;
        if (start) begin
          w_state_nx = w_skip ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (r_cnt == 5'd31) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 5'd0;
      r_op     <= 3'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_b      <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= 5'd0;
      r_op    <= funct3;
      r_hi    <= 32'd0;
      r_lo    <= funct3[2] ? w_a_mag : w_b_mag;
      r_b     <= funct3[2] ? w_b_mag : w_a_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_skip) begin
        r_result <= w_skip_res;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 5'd1;
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      if (r_cnt == 5'd31) begin
        r_result <= w_run_res;
      end
    end
  end

  assign result = r_result;

endmodule
